// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boots P_C, issues imem fetches over a req/ack
// handshake, and steers P_C loads for sequential advance, stalls and redirects.
module pc_sequencer #(
    parameter int               WIDTH     = 16,
    parameter int               STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'('h80)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_q,
    output logic             pc_en,
    output logic [WIDTH-1:0] pc_next,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    output logic             fetch_valid,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             exc,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Handshake: imem_req stays high until the cycle imem_ack=1; that cycle
    // completes the fetch, and a new request may start on the next cycle.

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_pend_v;
    logic             r_pend_exc;
    logic [WIDTH-1:0] r_pend_addr;
    logic             w_pend_v_nxt;
    logic             w_pend_exc_nxt;
    logic [WIDTH-1:0] w_pend_addr_nxt;

    logic             w_redir;
    logic [WIDTH-1:0] w_tgt;
    logic [WIDTH-1:0] w_seq;
    logic             w_stale;
    logic             w_take_new;
    logic             w_buf_wr;

    assign w_redir    = exc | jmp | br_taken;
    assign w_tgt      = exc ? EXC_VEC : (jmp ? jmp_target : br_target);
    assign w_seq      = pc_q + WIDTH'(STEP);
    assign w_stale    = r_pend_v | w_redir;
    // A buffered exception is only displaced by another exception.
    assign w_take_new = w_redir & ~(r_pend_v & r_pend_exc & ~exc);
    assign w_buf_wr   = (r_state == S_REQ) & ~imem_ack & w_redir & (~r_pend_exc | exc);

    assign imem_addr  = pc_q;
    assign dbg_state  = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_BOOT;
            r_pend_v    <= 1'b0;
            r_pend_exc  <= 1'b0;
            r_pend_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend_v    <= w_pend_v_nxt;
            r_pend_exc  <= w_pend_exc_nxt;
            r_pend_addr <= w_pend_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pend_v_nxt    = r_pend_v;
        w_pend_exc_nxt  = r_pend_exc;
        w_pend_addr_nxt = r_pend_addr;
        case (r_state)
            S_BOOT: w_state_nxt = S_REQ;
            S_REQ: begin
                if (!imem_ack) begin
                    if (w_buf_wr) begin
                        w_pend_v_nxt    = 1'b1;
                        w_pend_exc_nxt  = exc;
                        w_pend_addr_nxt = w_tgt;
                    end
                end else if (w_stale) begin
                    w_pend_v_nxt    = 1'b0;
                    w_pend_exc_nxt  = 1'b0;
                    w_pend_addr_nxt = '0;
                end else if (stall) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_redir || !stall) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // Outputs are Mealy; rst forces the quiescent values immediately.
    always_comb begin
        pc_en       = 1'b0;
        pc_next     = RESET_VEC;
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        busy        = 1'b0;
        if (!rst) begin
            case (r_state)
                S_BOOT: pc_en = 1'b1;
                S_REQ: begin
                    imem_req = 1'b1;
                    busy     = 1'b1;
                    if (imem_ack) begin
                        if (w_stale) begin
                            pc_en   = 1'b1;
                            pc_next = w_take_new ? w_tgt : r_pend_addr;
                        end else begin
                            fetch_valid = 1'b1;
                            if (!stall) begin
                                pc_en   = 1'b1;
                                pc_next = w_seq;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (w_redir) begin
                        pc_en   = 1'b1;
                        pc_next = w_tgt;
                    end else if (!stall) begin
                        pc_en   = 1'b1;
                        pc_next = w_seq;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
